// File: rtl/lsu_axi_param.sv
// In-order load/store unit: one op at a time, single-beat AXI4 read/write, sized/extended results.
// Optional macro LSU_PERF_CNT_EN adds perf_loads, perf_stores and perf_bus_cycles counters.
module lsu_axi_param #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 48,
  parameter int unsigned AXI_ID = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_ren,
  input  logic                in_wen,
  input  logic [2:0]          in_funct3,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_rdata,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_fault,
  output logic [1:0]          out_cause,
  output logic                busy,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [3:0]          awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [XLEN-1:0]     wdata,
  output logic [XLEN/8-1:0]   wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic [3:0]          bid,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [3:0]          arid,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [XLEN-1:0]     rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0]         perf_loads,
  output logic [31:0]         perf_stores,
  output logic [31:0]         perf_bus_cycles,
`endif
  input  logic [3:0]          rid
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RRESP, DONE} state_t;

  state_t             state;
  logic [2:0]         funct3_q;
  logic [OFF_W-1:0]   off_q;

  logic               is_store;
  logic               is_load;
  logic               illegal;
  logic               misaligned;
  logic [OFF_W-1:0]   in_off;
  logic [STRB_W-1:0]  size_mask;
  logic [XLEN-1:0]    wdata_sh;
  logic [STRB_W-1:0]  wstrb_sh;
  logic [XLEN-1:0]    rdata_sh;
  logic [XLEN-1:0]    load_ext;
  logic               unused_ok;

  assign unused_ok = ^{bid, rid, rlast};

  assign awid    = 4'(AXI_ID);
  assign arid    = 4'(AXI_ID);
  assign awlen   = 8'd0;
  assign arlen   = 8'd0;
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign wlast   = wvalid;

  // Legality, alignment and store-lane steering of the offered op.
  always_comb begin
    is_store   = in_wen;
    is_load    = in_ren & ~in_wen;
    illegal    = 1'b0;
    misaligned = 1'b0;
    in_off     = in_addr[OFF_W-1:0];
    size_mask  = STRB_W'(1);
    if (is_store)
      illegal = in_funct3[2] | ((in_funct3[1:0] == 2'b11) & (XLEN != 64));
    else if (is_load)
      illegal = (in_funct3 == 3'b111) |
                (((in_funct3 == 3'b011) | (in_funct3 == 3'b110)) & (XLEN != 64));
    case (in_funct3[1:0])
      2'b01:   misaligned = in_addr[0];
      2'b10:   misaligned = |in_addr[1:0];
      2'b11:   misaligned = |in_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    case (in_funct3[1:0])
      2'b00:   size_mask = STRB_W'(8'h01);
      2'b01:   size_mask = STRB_W'(8'h03);
      2'b10:   size_mask = STRB_W'(8'h0F);
      default: size_mask = STRB_W'(8'hFF);
    endcase
    wdata_sh = in_wdata << {in_off, 3'b000};
    wstrb_sh = size_mask << in_off;
  end

  // Load lane extraction; funct3[2] selects zero-extension.
  always_comb begin
    rdata_sh = rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = XLEN'($signed(rdata_sh[7:0]));
      3'b001:  load_ext = XLEN'($signed(rdata_sh[15:0]));
      3'b010:  load_ext = XLEN'($signed(rdata_sh[31:0]));
      3'b100:  load_ext = XLEN'(rdata_sh[7:0]);
      3'b101:  load_ext = XLEN'(rdata_sh[15:0]);
      3'b110:  load_ext = XLEN'(rdata_sh[31:0]);
      default: load_ext = rdata_sh;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      funct3_q  <= 3'd0;
      off_q     <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_tag   <= '0;
      out_fault <= 1'b0;
      out_cause <= 2'd0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      awsize    <= 3'd0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      arsize    <= 3'd0;
      rready    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            funct3_q  <= in_funct3;
            off_q     <= in_off;
            out_tag   <= in_tag;
            out_rdata <= '0;
            out_fault <= 1'b0;
            out_cause <= 2'd0;
            awaddr    <= in_addr;
            araddr    <= in_addr;
            awsize    <= {1'b0, in_funct3[1:0]};
            arsize    <= {1'b0, in_funct3[1:0]};
            wdata     <= wdata_sh;
            wstrb     <= wstrb_sh;
            if (!is_store && !is_load) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else if (illegal || misaligned) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_fault <= 1'b1;
              out_cause <= illegal ? 2'd3 : 2'd1;
            end else if (is_store) begin
              state   <= WREQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= RREQ;
              arvalid <= 1'b1;
            end
          end
        end
        WREQ: begin
          // AW and W complete independently, in either order.
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            state  <= WRESP;
            bready <= 1'b1;
          end
        end
        WRESP: begin
          if (bvalid) begin
            state     <= DONE;
            bready    <= 1'b0;
            out_valid <= 1'b1;
            out_fault <= (bresp != 2'b00);
            out_cause <= (bresp != 2'b00) ? 2'd2 : 2'd0;
          end
        end
        RREQ: begin
          if (arready) begin
            state   <= RRESP;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        RRESP: begin
          if (rvalid) begin
            state     <= DONE;
            rready    <= 1'b0;
            out_valid <= 1'b1;
            if (rresp != 2'b00) begin
              out_fault <= 1'b1;
              out_cause <= 2'd2;
              out_rdata <= '0;
            end else begin
              out_rdata <= load_ext;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  // Event counters; wrap naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_loads      <= 32'd0;
      perf_stores     <= 32'd0;
      perf_bus_cycles <= 32'd0;
    end else begin
      if (state == RRESP && rvalid) perf_loads  <= perf_loads + 32'd1;
      if (state == WRESP && bvalid) perf_stores <= perf_stores + 32'd1;
      if (state == WREQ || state == WRESP || state == RREQ || state == RRESP)
        perf_bus_cycles <= perf_bus_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lsu_axi_param.sv
// Directed bench for lsu_axi_param: 32-bit instance with a hand-driven slave, 64-bit instance for wide loads.
module tb_lsu_axi_param;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // 32-bit instance
  logic        in_valid, in_ready, in_ren, in_wen;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [47:0] in_tag;
  logic        out_valid, out_ready, out_fault, busy;
  logic [31:0] out_rdata;
  logic [47:0] out_tag;
  logic [1:0]  out_cause;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awid, arid, bid, rid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  // 64-bit instance
  logic        x_in_valid, x_in_ready, x_in_ren, x_in_wen;
  logic [2:0]  x_in_funct3;
  logic [31:0] x_in_addr;
  logic [63:0] x_in_wdata;
  logic [47:0] x_in_tag;
  logic        x_out_valid, x_out_ready, x_out_fault, x_busy;
  logic [63:0] x_out_rdata;
  logic [47:0] x_out_tag;
  logic [1:0]  x_out_cause;
  logic        x_awvalid, x_awready, x_wvalid, x_wready, x_wlast, x_bvalid, x_bready;
  logic        x_arvalid, x_arready, x_rvalid, x_rready, x_rlast;
  logic [31:0] x_awaddr, x_araddr;
  logic [63:0] x_wdata, x_rdata;
  logic [7:0]  x_wstrb, x_awlen, x_arlen;
  logic [3:0]  x_awid, x_arid, x_bid, x_rid;
  logic [2:0]  x_awsize, x_arsize;
  logic [1:0]  x_awburst, x_arburst, x_bresp, x_rresp;

  int total = 0;
  int fails = 0;
  int wbeats = 0;
  int ar_seen = 0;
  int snap;

  lsu_axi_param #(.XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_tag(out_tag),
    .out_fault(out_fault), .out_cause(out_cause), .busy(busy),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  lsu_axi_param #(.XLEN(64)) dut64 (
    .clock(clock), .reset(reset),
    .in_valid(x_in_valid), .in_ready(x_in_ready), .in_ren(x_in_ren), .in_wen(x_in_wen),
    .in_funct3(x_in_funct3), .in_addr(x_in_addr), .in_wdata(x_in_wdata), .in_tag(x_in_tag),
    .out_valid(x_out_valid), .out_ready(x_out_ready), .out_rdata(x_out_rdata), .out_tag(x_out_tag),
    .out_fault(x_out_fault), .out_cause(x_out_cause), .busy(x_busy),
    .awvalid(x_awvalid), .awready(x_awready), .awaddr(x_awaddr), .awid(x_awid), .awlen(x_awlen),
    .awsize(x_awsize), .awburst(x_awburst),
    .wvalid(x_wvalid), .wready(x_wready), .wdata(x_wdata), .wstrb(x_wstrb), .wlast(x_wlast),
    .bvalid(x_bvalid), .bready(x_bready), .bresp(x_bresp), .bid(x_bid),
    .arvalid(x_arvalid), .arready(x_arready), .araddr(x_araddr), .arid(x_arid), .arlen(x_arlen),
    .arsize(x_arsize), .arburst(x_arburst),
    .rvalid(x_rvalid), .rready(x_rready), .rdata(x_rdata), .rresp(x_rresp), .rlast(x_rlast), .rid(x_rid)
  );

  always @(posedge clock) begin
    if (wvalid && wready) wbeats <= wbeats + 1;
    if (arvalid) ar_seen <= ar_seen + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [47:0] tag);
    in_valid = 1'b1; in_ren = ren; in_wen = wen; in_funct3 = f3;
    in_addr = addr; in_wdata = wd; in_tag = tag;
    step();
    in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic load64(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [63:0] rd, input logic [63:0] exp);
    x_in_valid = 1'b1; x_in_ren = 1'b1; x_in_funct3 = f3; x_in_addr = addr;
    step();
    x_in_valid = 1'b0; x_in_ren = 1'b0;
    chk({tag, "_arsize"}, 64'(x_arsize), 64'({1'b0, f3[1:0]}));
    step();
    x_rvalid = 1'b1; x_rdata = rd;
    step();
    x_rvalid = 1'b0;
    chk({tag, "_valid"}, 64'(x_out_valid), 64'd1);
    chk({tag, "_rdata"}, x_out_rdata, exp);
    x_out_ready = 1'b1;
    step();
    x_out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 0; in_ren = 0; in_wen = 0; in_funct3 = 0; in_addr = 0; in_wdata = 0; in_tag = 0;
    out_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0;
    x_in_valid = 0; x_in_ren = 0; x_in_wen = 0; x_in_funct3 = 0; x_in_addr = 0; x_in_wdata = 0;
    x_in_tag = 0; x_out_ready = 0; x_awready = 1; x_wready = 1; x_bvalid = 0; x_bresp = 0;
    x_bid = 0; x_arready = 1; x_rvalid = 0; x_rdata = 0; x_rresp = 0; x_rlast = 0; x_rid = 0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_axi_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_cause", 64'({out_fault, out_cause}), 64'd0);
    reset = 1'b0;
    step();

    // lb from top byte lane, sign-extended
    offer(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0, 48'h1234_5678_9ABC);
    chk("lb_arvalid", 64'(arvalid), 64'd1);
    chk("lb_arsize", 64'(arsize), 64'd0);
    chk("lb_araddr", 64'(araddr), 64'h8000_0003);
    chk("lb_in_ready", 64'(in_ready), 64'd0);
    arready = 1'b1; step(); arready = 1'b0;
    chk("lb_rready", 64'(rready), 64'd1);
    chk("lb_ar_clear", 64'(arvalid), 64'd0);
    chk("lb_not_early", 64'(out_valid), 64'd0);
    rvalid = 1'b1; rdata = 32'h80FF_1234; step(); rvalid = 1'b0;
    chk("lb_out_valid", 64'(out_valid), 64'd1);
    chk("lb_rdata", 64'(out_rdata), 64'hFFFF_FF80);
    chk("lb_tag", 64'(out_tag), 64'h1234_5678_9ABC);
    chk("lb_fault", 64'(out_fault), 64'd0);
    release_out();
    chk("lb_release", 64'({out_valid, in_ready}), 64'b01);

    // sh at offset 2, AW stalled four cycles, W immediate
    snap = wbeats;
    offer(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 48'h55);
    chk("sh_aw_w_valid", 64'({awvalid, wvalid}), 64'b11);
    chk("sh_wdata", 64'(wdata), 64'hBEEF_0000);
    chk("sh_wstrb", 64'(wstrb), 64'hC);
    chk("sh_wlast", 64'(wlast), 64'd1);
    chk("sh_awsize", 64'(awsize), 64'd1);
    wready = 1'b1; step(); wready = 1'b0;
    chk("sh_w_clear", 64'({awvalid, wvalid}), 64'b10);
    step(); step();
    chk("sh_bready_wait", 64'(bready), 64'd0);
    awready = 1'b1; step(); awready = 1'b0;
    chk("sh_aw_clear", 64'(awvalid), 64'd0);
    chk("sh_bready", 64'(bready), 64'd1);
    step();
    chk("sh_wait_b", 64'(out_valid), 64'd0);
    bvalid = 1'b1; step(); bvalid = 1'b0;
    chk("sh_out_valid", 64'(out_valid), 64'd1);
    chk("sh_result", 64'({out_fault, out_cause, out_rdata}), 64'd0);
    chk("sh_wbeats", 64'(wbeats - snap), 64'd1);
    release_out();

    // misaligned lw faults without bus activity
    snap = ar_seen;
    offer(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'd0, 48'h7);
    chk("mis_valid", 64'(out_valid), 64'd1);
    chk("mis_fault", 64'({out_fault, out_cause}), 64'b101);
    release_out();
    step();
    chk("mis_no_ar", 64'(ar_seen - snap), 64'd0);

    // lhu with slave error
    offer(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'd0, 48'h8);
    arready = 1'b1; step(); arready = 1'b0;
    rvalid = 1'b1; rresp = 2'b10; rdata = 32'h1234_5678; step(); rvalid = 1'b0; rresp = 2'b00;
    chk("berr_fault", 64'({out_valid, out_fault, out_cause}), 64'b1110);
    chk("berr_rdata", 64'(out_rdata), 64'd0);
    release_out();

    // store funct3 011 on 32-bit: illegal wins over misaligned
    offer(1'b0, 1'b1, 3'b011, 32'h0000_0001, 32'd0, 48'h9);
    chk("ill_cause", 64'({out_valid, out_fault, out_cause}), 64'b1111);
    release_out();

    // pass-through
    offer(1'b0, 1'b0, 3'b000, 32'h0, 32'd0, 48'hFEED_0000_BEEF);
    chk("pt_result", 64'({out_valid, out_fault, out_cause}), 64'b1000);
    chk("pt_tag", 64'(out_tag), 64'hFEED_0000_BEEF);
    release_out();

    // lh result held while writeback stalls
    offer(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'd0, 48'hA);
    arready = 1'b1; step(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h8001_0000; step(); rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'({out_valid, in_ready}), 64'b10);
      chk("stall_rdata", 64'(out_rdata), 64'hFFFF_8001);
      step();
    end
    release_out();

    // async reset while waiting for R
    offer(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'd0, 48'hB);
    arready = 1'b1; step(); arready = 1'b0;
    chk("rr_rready", 64'(rready), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_drop", 64'({rready, busy, arvalid}), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    #1 reset = 1'b0;
    step();
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    chk("orphan_rready", 64'({rready, out_valid, in_ready}), 64'b001);
    rvalid = 1'b0;

    // 64-bit loads
    load64("ld", 3'b011, 32'h8, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    load64("lwu", 3'b110, 32'hC, 64'hF000_0000_1234_5678, 64'h0000_0000_F000_0000);
    load64("lw64", 3'b010, 32'hC, 64'hF000_0000_1234_5678, 64'hFFFF_FFFF_F000_0000);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/lsu_axi_param.md
Name: lsu_axi_param

Overview:
- Parametrised in-order load/store unit sitting between the execute stage and the AXI4 data-bus arbiter.
- Accepts one memory op at a time through a valid/ready handshake and issues a single-beat AXI4 read or write with independent AW/W handshakes.
- Checks alignment and funct3 legality before touching the bus; reports bus error responses.
- Returns the sized, sign- or zero-extended result with a sideband tag (rd, wen flags, etc.) to writeback.

Parameters:
XLEN, 32, data width; 32 or 64 (64 enables ld/sd/lwu)
ADDR_W, 32, address width
TAG_W, 48, opaque sideband carried from input to output unchanged
AXI_ID, 0, constant value driven on awid/arid (4 bits)

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high
in_valid  in  1  op offered
in_ready  out  1  unit can accept
in_ren / in_wen  in  1 each  load / store (neither set = pass-through)
in_funct3  in  3  RISC-V size/sign code
in_addr  in  ADDR_W  effective address
in_wdata  in  XLEN  store data (low bytes significant)
in_tag  in  TAG_W  sideband
out_valid  out  1  result available
out_ready  in  1  writeback accepts
out_rdata  out  XLEN  extended load data; 0 for store, pass-through or fault
out_tag  out  TAG_W  captured sideband
out_fault  out  1  op faulted
out_cause  out  2  0 none, 1 misaligned, 2 bus error, 3 illegal funct3
busy  out  1  state != IDLE
AXI4 master: aw{valid,ready,addr[ADDR_W],id[4],len[8],size[3],burst[2]}, w{valid,ready,data[XLEN],strb[XLEN/8],last}, b{valid,ready,resp[2],id[4]}, ar{valid,ready,addr,id,len,size,burst}, r{valid,ready,data[XLEN],resp[2],last,id[4]}

Behaviour:
- Reset (async): state IDLE. All valid/ready outputs 0 except in_ready=1; out_fault=0, out_cause=0, out_rdata=0, out_tag=0.
- States: IDLE, WREQ, WRESP, RREQ, RRESP, DONE. in_ready=1 only in IDLE. Accept = in_valid & in_ready; addr, funct3, wdata, tag are registered on accept.
- At accept:
  - Neither ren nor wen -> DONE, no fault.
  - Illegal funct3 (load 011/110 with XLEN=32, load 111, store funct3[2]=1, store 011 with XLEN=32) -> DONE with cause 3; illegal is checked before misaligned.
  - Misaligned (half addr[0]!=0, word addr[1:0]!=0, double addr[2:0]!=0) -> DONE with cause 1, no bus activity.
  - Otherwise store -> WREQ, load -> RREQ.
- WREQ: awvalid and wvalid are set the cycle after accept. Each clears on its own handshake; the two may complete in either order or the same cycle. When both are done -> WRESP.
- WRESP: bready=1; on bvalid, capture bresp!=0 as cause 2 -> DONE.
- RREQ: arvalid set the cycle after accept; on arready -> RRESP.
- RRESP: rready=1; on rvalid, register extended data (or 0 with cause 2 if rresp!=0) -> DONE.
- bid, rid and rlast are ignored.
- Bus field encodings:
  - len=0, burst=01, size={0,funct3[1:0]} from the registered funct3, addr=registered address unchanged.
  - wlast=wvalid.
  - wdata = store data shifted left by 8*addr[log2(XLEN/8)-1:0]; wstrb = size mask (1/3/F/FF) shifted by the same byte offset.
- Load extraction: byte lane at the address offset; funct3 bit2 selects zero-extend, otherwise sign-extend to XLEN. lw on XLEN=64 sign-extends; lwu zero-extends.
- DONE: out_valid=1 with out_rdata, out_tag, out_fault, out_cause held stable until out_ready, then -> IDLE. The next accept is no earlier than the following cycle.
- Latency (zero-wait slave, ready every cycle):
  - Load: accept at t0, arvalid at t1, rvalid at t2, out_valid at t3.
  - Store: AW/W at t1, bvalid at t2, out_valid at t3.
  - Fault or pass-through: out_valid at t1.
- Async reset mid-transaction: all AXI valids drop immediately and state returns to IDLE. Orphaned slave responses arriving in IDLE are not acknowledged (bready=rready=0).

Optional Feature:
LSU_PERF_CNT_EN:
- Defined: adds 32-bit outputs perf_loads, perf_stores and perf_bus_cycles, all reset to 0.
  - perf_loads / perf_stores increment on each completed bus load/store, i.e. entering DONE from RRESP/WRESP, faults included.
  - perf_bus_cycles increments every cycle the state is WREQ, WRESP, RREQ or RRESP.
  - All counters wrap at 2^32.
- Undefined: these ports and the counter logic do not exist.

Test Plan:
- XLEN=32: lb, addr 0x80000003, rdata 0x80FF1234 -> arsize 0, out_rdata 0xFFFFFF80, out_valid 3 cycles after accept, tag echoed.
- XLEN=32: sh, addr 0x80000002, wdata 0x0000BEEF; awready held low 4 cycles, wready immediate -> wdata 0xBEEF0000, wstrb 0xC, single W beat, out_valid only after bvalid.
- lw at 0x80000001 -> out_fault=1, out_cause=1 at t1, no arvalid ever asserted.
- lhu, addr 0x10; rresp=2'b10, rdata 0x12345678 -> out_cause=2, out_rdata=0.
- XLEN=64: ld at 0x8, rdata 0x8000000000000001 -> out_rdata unchanged; lwu at 0xC with rdata upper word 0xF0000000 -> 0x00000000F0000000.
- Load result with out_ready low 5 cycles -> outputs stable and in_ready=0 throughout. Separately, async reset asserted during RRESP -> rready and busy drop the same cycle, in_ready=1.
